// File: rtl/uart_rx_param_pkg.sv
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types, legal-range constants and helpers for the
//                parametrised UART receiver.
//  Contents    : rx_state_t  - receiver FSM state encoding
//                calc_parity - expected parity bit for a data word
//                c_*         - legal ranges for the receiver parameters
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package uart_pkg;

    // Receiver FSM states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    // Legal parameter ranges
    localparam int c_DATA_BITS_MIN  = 5;
    localparam int c_DATA_BITS_MAX  = 9;
    localparam int c_STOP_BITS_MIN  = 1;
    localparam int c_STOP_BITS_MAX  = 2;
    localparam int c_OVERSAMPLE_MIN = 8;

    // Parity bit a transmitter would send for this word. Narrower words are
    // zero-extended, which leaves the XOR unchanged.
    function automatic logic calc_parity(input logic [8:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage : uart_pkg

`default_nettype wire

// File: rtl/uart_rx_param_if.sv
// ============================================================================
//  Module      : uart_rx_param_if
//  Description : Receive-side handshake bundle between the UART receiver and
//                its consumer (host or FIFO).
//  Signals     : rx_data    - received word
//                rx_valid   - rx_data and error flags are valid
//                rx_ready   - consumer accepts when rx_valid && rx_ready
//                frame_err  - stop-bit error, qualified by rx_valid
//                parity_err - parity error, qualified by rx_valid
//                overrun    - one-cycle pulse when a frame is dropped
//                busy       - receiver is inside a frame
//  Modports    : master - receiver side, slave - consumer side
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun;
    logic                 busy;

    modport master (
        output rx_data, rx_valid, frame_err, parity_err, overrun, busy,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, frame_err, parity_err, overrun, busy,
        output rx_ready
    );
endinterface : uart_rx_param_if

`default_nettype wire

// File: rtl/uart_rx_param_sync.sv
// ============================================================================
//  Module      : uart_rx_sync
//  Description : Two-flop synchroniser for an asynchronous idle-high line plus
//                a falling-edge detector. The previous-value flop advances only
//                on enable cycles, so an edge is seen at the enable rate and a
//                line held low cannot produce a second edge.
//  Ports       : clk, rst - clock, synchronous active-high reset
//                i_en     - sampling enable (baud tick)
//                i_rx     - asynchronous line input
//                o_rxs    - synchronised line
//                o_fall   - 1 on an enable cycle where the line went 1 -> 0
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_rx_sync
    import uart_pkg::*;
(
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_en,
    input  wire logic i_rx,
    output logic      o_rxs,
    output logic      o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // All flops reset to the idle-high level so leaving reset never looks
    // like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_rx;
            r_sync <= r_meta;
            if (i_en) begin
                r_prev <= r_sync;
            end
        end
    end

    assign o_rxs  = r_sync;
    assign o_fall = i_en & r_prev & ~r_sync;

endmodule : uart_rx_sync

`default_nettype wire

// File: rtl/uart_rx_param.sv
// ============================================================================
//  Module      : uart_rx_param
//  Description : Parametrised UART receiver with N-times oversampling and
//                mid-bit sampling, false-start rejection, parity and framing
//                error flags, and a valid/ready output with overrun detect.
//  Parameters  : DATA_BITS (5..9), PARITY_EN, PARITY_ODD, STOP_BITS (1..2),
//                OVERSAMPLE (even, >= 8)
//  Ports       : clk, rst   - clock, synchronous active-high reset
//                baud_tick  - one-cycle pulse at OVERSAMPLE x baud rate
//                rx         - asynchronous serial line, idle high
//                rx_if      - receive handshake bundle (master side)
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
)(
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          baud_tick,
    input  wire logic          rx,
    uart_rx_param_if.master    rx_if
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------------
    if ((DATA_BITS < c_DATA_BITS_MIN) || (DATA_BITS > c_DATA_BITS_MAX)) begin : g_chk_data_bits
        $error("uart_rx_param: DATA_BITS must be in 5..9");
    end
    if ((STOP_BITS < c_STOP_BITS_MIN) || (STOP_BITS > c_STOP_BITS_MAX)) begin : g_chk_stop_bits
        $error("uart_rx_param: STOP_BITS must be 1 or 2");
    end
    if ((OVERSAMPLE < c_OVERSAMPLE_MIN) || ((OVERSAMPLE % 2) != 0)) begin : g_chk_oversample
        $error("uart_rx_param: OVERSAMPLE must be even and at least 8");
    end

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);

    // The edge tick is the first tick of the start bit and the counter is
    // cleared on it, so the mid-start sample lands when the counter reads
    // OVERSAMPLE/2-2 (the OVERSAMPLE/2-th tick of the bit).
    localparam logic [CW-1:0] c_tick_mid  = CW'(OVERSAMPLE / 2 - 2);
    localparam logic [CW-1:0] c_tick_last = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] c_tick_one  = CW'(1);
    localparam logic [BW-1:0] c_bit_last  = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] c_stop_last = BW'(STOP_BITS - 1);
    localparam logic [BW-1:0] c_bit_one   = BW'(1);
    localparam logic          c_par_odd   = (PARITY_ODD != 0);
    localparam rx_state_t     c_after_data = (PARITY_EN != 0) ? PARITY : STOP;

    // ------------------------------------------------------------------------
    // Line synchroniser
    // ------------------------------------------------------------------------
    logic w_rxs;
    logic w_fall;

    uart_rx_sync u_sync (
        .clk    (clk),
        .rst    (rst),
        .i_en   (baud_tick),
        .i_rx   (rx),
        .o_rxs  (w_rxs),
        .o_fall (w_fall)
    );

    // ------------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------------
    rx_state_t            r_state,    w_state_nxt;
    logic [CW-1:0]        r_tick_cnt, w_tick_cnt_nxt;
    logic [BW-1:0]        r_bit_cnt,  w_bit_cnt_nxt;
    logic [DATA_BITS-1:0] r_shift,    w_shift_nxt;
    logic                 r_ferr,     w_ferr_nxt;
    logic                 r_perr,     w_perr_nxt;
    logic                 w_commit;
    logic                 w_mid;

    // Mid-bit sampling tick for the DATA/PARITY/STOP states
    assign w_mid = baud_tick && (r_tick_cnt == c_tick_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_ferr     <= 1'b0;
            r_perr     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_tick_cnt <= w_tick_cnt_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_ferr     <= w_ferr_nxt;
            r_perr     <= w_perr_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_tick_cnt_nxt = r_tick_cnt;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_shift_nxt    = r_shift;
        w_ferr_nxt     = r_ferr;
        w_perr_nxt     = r_perr;
        w_commit       = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (w_fall) begin
                    w_state_nxt    = START;
                    w_tick_cnt_nxt = '0;
                end
            end

            START: begin
                if (baud_tick) begin
                    if (r_tick_cnt == c_tick_mid) begin
                        if (w_rxs) begin
                            // Line back high at mid-start: glitch, not a frame
                            w_state_nxt = IDLE;
                        end else begin
                            w_state_nxt    = DATA;
                            w_tick_cnt_nxt = '0;
                            w_bit_cnt_nxt  = '0;
                            w_ferr_nxt     = 1'b0;
                            w_perr_nxt     = 1'b0;
                        end
                    end else begin
                        w_tick_cnt_nxt = r_tick_cnt + c_tick_one;
                    end
                end
            end

            DATA: begin
                if (w_mid) begin
                    w_tick_cnt_nxt = '0;
                    // LSB arrives first; after DATA_BITS shifts it sits at bit 0
                    w_shift_nxt    = {w_rxs, r_shift[DATA_BITS-1:1]};
                    if (r_bit_cnt == c_bit_last) begin
                        w_bit_cnt_nxt = '0;
                        w_state_nxt   = c_after_data;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + c_bit_one;
                    end
                end else if (baud_tick) begin
                    w_tick_cnt_nxt = r_tick_cnt + c_tick_one;
                end
            end

            PARITY: begin
                if (w_mid) begin
                    w_tick_cnt_nxt = '0;
                    w_bit_cnt_nxt  = '0;
                    w_perr_nxt     = calc_parity(9'(r_shift), c_par_odd) ^ w_rxs;
                    w_state_nxt    = STOP;
                end else if (baud_tick) begin
                    w_tick_cnt_nxt = r_tick_cnt + c_tick_one;
                end
            end

            STOP: begin
                if (w_mid) begin
                    w_tick_cnt_nxt = '0;
                    w_ferr_nxt     = r_ferr | ~w_rxs;
                    if (r_bit_cnt == c_stop_last) begin
                        // Leave at mid-stop so a start edge in the second
                        // half of the stop bit is still caught.
                        w_commit    = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + c_bit_one;
                    end
                end else if (baud_tick) begin
                    w_tick_cnt_nxt = r_tick_cnt + c_tick_one;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output holding register and valid/ready handshake
    // ------------------------------------------------------------------------
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_frame_err;
    logic                 r_parity_err;
    logic                 r_overrun;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_commit) begin
                // The holding register is free if empty or emptied this cycle
                if (!r_valid || rx_if.rx_ready) begin
                    r_data       <= r_shift;
                    r_frame_err  <= w_ferr_nxt;
                    r_parity_err <= r_perr;
                    r_valid      <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && rx_if.rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_if.rx_data    = r_data;
    assign rx_if.rx_valid   = r_valid;
    assign rx_if.frame_err  = r_frame_err;
    assign rx_if.parity_err = r_parity_err;
    assign rx_if.overrun    = r_overrun;
    assign rx_if.busy       = (r_state != IDLE);

endmodule : uart_rx_param

`default_nettype wire
